// File: rtl/window_5x5_gen.sv
// Turns a raster 8-bit pixel stream into 5x5 windows using four line buffers and a 5x5 shift array.
// One-cycle latency from the accepting edge to window_valid; a single output register gives bubble-free backpressure.
module window_5x5_gen #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   pix_in,
  input  logic         pix_valid,
  output logic         pix_ready,
  output logic [199:0] window_out,
  output logic         window_valid,
  input  logic         window_ready,
  output logic         window_last,
  output logic [11:0]  win_x,
  output logic [11:0]  win_y
);
  localparam int          AW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [11:0] X_LAST = 12'(IMG_WIDTH - 1);
  localparam logic [11:0] Y_LAST = 12'(IMG_HEIGHT - 1);

  typedef enum logic {FILL, STREAM} state_t;

  state_t                 state_q, state_d;
  logic [11:0]            x_q, x_d, y_q, y_d;
  logic [4:0][4:0][7:0]   win_q, win_d;
  logic [7:0]             lb_q [4][IMG_WIDTH];
  logic [AW-1:0]          xi;
  logic [199:0]           out_q;
  logic                   vld_q, last_q;
  logic [11:0]            wx_q, wy_q;
  logic                   accept, x_last, y_last, frame_end, emit;

  assign pix_ready    = !vld_q || window_ready;
  assign accept       = pix_valid && pix_ready;
  assign xi           = x_q[AW-1:0];
  assign x_last       = (x_q == X_LAST);
  assign y_last       = (y_q == Y_LAST);
  assign frame_end    = accept && x_last && y_last;
  assign window_out   = out_q;
  assign window_valid = vld_q;
  assign window_last  = last_q;
  assign win_x        = wx_q;
  assign win_y        = wy_q;

  always_comb begin
    win_d   = win_q;
    x_d     = x_q;
    y_d     = y_q;
    state_d = state_q;
    emit    = 1'b0;
    if (accept) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      // Right-hand column: oldest line at the top, the incoming pixel at the bottom.
      win_d[0][4] = lb_q[3][xi];
      win_d[1][4] = lb_q[2][xi];
      win_d[2][4] = lb_q[1][xi];
      win_d[3][4] = lb_q[0][xi];
      win_d[4][4] = pix_in;
      if (x_last) begin
        x_d = 12'd0;
        y_d = y_last ? 12'd0 : y_q + 12'd1;
      end else begin
        x_d = x_q + 12'd1;
      end
    end
    case (state_q)
      FILL: begin
        if (accept && x_last && (y_q == 12'd3)) state_d = STREAM;
      end
      STREAM: begin
        emit = accept && (x_q >= 12'd4);
        if (frame_end) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      x_q     <= 12'd0;
      y_q     <= 12'd0;
      win_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      wx_q    <= 12'd0;
      wy_q    <= 12'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      win_q   <= win_d;
      if (emit) begin
        out_q  <= win_d;
        vld_q  <= 1'b1;
        last_q <= frame_end;
        wx_q   <= x_q - 12'd2;
        wy_q   <= y_q - 12'd2;
      end else if (window_ready) begin
        vld_q  <= 1'b0;
        last_q <= 1'b0;
      end
    end
  end

  // Line-buffer contents are don't-care after reset; the y<4 gating hides them.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_q[0][xi] <= pix_in;
      lb_q[1][xi] <= lb_q[0][xi];
      lb_q[2][xi] <= lb_q[1][xi];
      lb_q[3][xi] <= lb_q[2][xi];
    end
  end

endmodule

// File: tb/tb_window_5x5_gen.sv
// Scoreboard bench for window_5x5_gen on an 8x6 frame with pixel value 16*y + x (+ frame offset).
module tb_window_5x5_gen;
  localparam int W = 8;
  localparam int H = 6;

  typedef struct packed {
    logic [199:0] w;
    logic [11:0]  x;
    logic [11:0]  y;
    logic         last;
    logic [7:0]   off;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   pix_in;
  logic         pix_valid;
  logic         pix_ready;
  logic [199:0] window_out;
  logic         window_valid;
  logic         window_ready;
  logic         window_last;
  logic [11:0]  win_x;
  logic [11:0]  win_y;

  int   errors = 0;
  int   checks = 0;
  int   total_wins = 0;
  exp_t sb[$];

  window_5x5_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .window_out(window_out), .window_valid(window_valid), .window_ready(window_ready),
    .window_last(window_last), .win_x(win_x), .win_y(win_y)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pix(input int x, input int y, input logic [7:0] off);
    return 8'(16 * y + x) + off;
  endfunction

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drives one cycle; outputs are sampled on the falling edge, and a consumed window is scored.
  task automatic cycle(input logic pv, input logic [7:0] pd, input logic wr, output bit acc);
    exp_t e;
    pix_valid    = pv;
    pix_in       = pd;
    window_ready = wr;
    @(negedge clk);
    if (window_valid && window_ready) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL spurious_window observed=window with empty scoreboard expected=no window");
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("window_out", window_out, e.w);
        chk("win_x", 200'(win_x), 200'(e.x));
        chk("win_y", 200'(win_y), 200'(e.y));
        chk("window_last", 200'(window_last), 200'(e.last));
        if (e.x == 12'd2 && e.y == 12'd2) begin
          chk("first_r0c0", 200'(window_out[7:0]), 200'(e.off));
          chk("first_centre", 200'(window_out[96 +: 8]), 200'(8'(e.off + 8'h22)));
          chk("first_r4c4", 200'(window_out[192 +: 8]), 200'(8'(e.off + 8'h44)));
        end
        if (e.last) chk("last_r4c4", 200'(window_out[192 +: 8]), 200'(8'(e.off + 8'h57)));
        total_wins++;
      end
    end
    acc = pix_valid && pix_ready;
    @(posedge clk);
    #1;
  endtask

  // mode 0: continuous, 1: random gaps on both sides, 2: continuous with one 3-cycle stall.
  task automatic run_frame(input logic [7:0] off, input int mode, input int npix, input bit drain);
    int           n = 0;
    int           guard = 0;
    int           d = 0;
    int           x;
    int           y;
    bit           acc;
    bit           stalled = 0;
    logic         pv;
    logic         wr;
    exp_t         e;
    logic [199:0] held;
    while (n < npix && guard < 3000) begin
      guard++;
      x = n % W;
      y = n / W;
      if (mode == 2 && !stalled && window_valid) begin
        stalled = 1;
        held = window_out;
        for (int k = 0; k < 3; k++) begin
          cycle(1'b1, pix(x, y, off), 1'b0, acc);
          chk("stall_accept", 200'(acc), 200'(0));
          chk("stall_pix_ready", 200'(pix_ready), 200'(0));
          chk("stall_hold", window_out, held);
        end
      end
      pv = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      wr = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle(pv, pix(x, y, off), wr, acc);
      if (acc) begin
        if (x >= 4 && y >= 4) begin
          e.w = '0;
          for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
              e.w[40*r + 8*c +: 8] = pix(x - 4 + c, y - 4 + r, off);
            end
          end
          e.x    = 12'(x - 2);
          e.y    = 12'(y - 2);
          e.last = (x == W - 1) && (y == H - 1);
          e.off  = off;
          sb.push_back(e);
        end
        n++;
      end
    end
    chk("frame_pixels", 200'(n), 200'(npix));
    if (drain) begin
      while (sb.size() > 0 && d < 50) begin
        cycle(1'b0, 8'h00, 1'b1, acc);
        d++;
      end
      chk("drain_empty", 200'(sb.size()), 200'(0));
    end
  endtask

  initial begin
    int base;
    bit acc;
    rst          = 1'b1;
    pix_valid    = 1'b0;
    pix_in       = 8'h00;
    window_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_window_valid", 200'(window_valid), 200'(0));
    chk("rst_window_last", 200'(window_last), 200'(0));
    chk("rst_win_x", 200'(win_x), 200'(0));
    chk("rst_win_y", 200'(win_y), 200'(0));
    chk("rst_window_out", window_out, 200'(0));
    chk("rst_pix_ready", 200'(pix_ready), 200'(1));
    rst = 1'b0;

    base = total_wins;
    run_frame(8'h00, 0, 48, 1'b1);
    chk("count_continuous", 200'(total_wins - base), 200'(8));

    base = total_wins;
    run_frame(8'h00, 2, 48, 1'b1);
    chk("count_stall", 200'(total_wins - base), 200'(8));

    run_frame(8'h00, 0, 20, 1'b0);
    rst          = 1'b1;
    pix_valid    = 1'b1;
    window_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_window_valid", 200'(window_valid), 200'(0));
    chk("midrst_pix_ready", 200'(pix_ready), 200'(1));
    sb.delete();
    base = total_wins;
    run_frame(8'h00, 0, 48, 1'b1);
    chk("count_after_reset", 200'(total_wins - base), 200'(8));

    base = total_wins;
    run_frame(8'h00, 0, 48, 1'b0);
    run_frame(8'h80, 0, 48, 1'b1);
    chk("count_back_to_back", 200'(total_wins - base), 200'(16));

    base = total_wins;
    run_frame(8'h00, 1, 48, 1'b1);
    chk("count_random_a", 200'(total_wins - base), 200'(8));
    base = total_wins;
    run_frame(8'h80, 1, 48, 1'b1);
    chk("count_random_b", 200'(total_wins - base), 200'(8));

    cycle(1'b0, 8'h00, 1'b1, acc);
    chk("idle_window_valid", 200'(window_valid), 200'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/window_5x5_gen.md
Name: window_5x5_gen

Overview:
- Streaming line-buffer window generator that turns a raster pixel stream (row-major, 8-bit) into 5x5 neighbourhood windows.
- Produces the 200-bit packed window bus consumed by the 5x5 convolution kernels (edge, blur) in the post-decode image pipeline.
- Sits between the decoder's pixel output and the kernel stage.
- Emits one window per input pixel once a full 5x5 neighbourhood exists; no border padding.

Parameters:
- IMG_WIDTH, 64, pixels per line; legal range 5..4096.
- IMG_HEIGHT, 64, lines per frame; legal range 5..4096.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- pix_in  input  8  input pixel, raster order.
- pix_valid  input  1  pix_in is valid.
- pix_ready  output  1  block accepts pix_in this cycle.
- window_out  output  200  packed 5x5 window. Row r (0 = top/oldest line), column c (0 = left/oldest) occupies bits [40r+8c+7 : 40r+8c].
- window_valid  output  1  window_out is valid.
- window_ready  input  1  downstream accepts the window.
- window_last  output  1  qualifies window_valid; marks the final window of the frame.
- win_x  output  12  centre column of the current window (x-2).
- win_y  output  12  centre row of the current window (y-2).

Behaviour:
- Reset: rst=1 at a clock edge clears the x/y counters, state, window_valid, window_last, win_x, win_y and window_out to 0. Line-buffer RAM contents need not be cleared. Reset takes priority over all other events, including mid-frame and mid-handshake; the next accepted pixel after reset is (0,0).
- Handshake:
  - pix_ready = !window_valid || window_ready (single output register, no bubble).
  - A pixel is accepted when pix_valid && pix_ready.
  - A window is consumed when window_valid && window_ready.
  - While window_valid=1 and window_ready=0, window_out, window_last, win_x and win_y hold stable.
- Storage:
  - 4 line buffers of IMG_WIDTH x 8 bits.
  - 5x5 register array that shifts left one column per accepted pixel.
  - The new column is {lb3[x], lb2[x], lb1[x], lb0[x], pix_in}, top to bottom. lb3 holds line y-4.
  - On the same accept, lbk[x] is rotated: lb0 takes pix_in, lb(k+1) takes the old lbk.
- Counters: x increments on each accept. At x=IMG_WIDTH-1, x wraps to 0 and y increments. At (IMG_WIDTH-1, IMG_HEIGHT-1), both wrap to 0 (end of frame).
- FSM:
  - FILL: y<4; no window is produced. Go to STREAM when accepting pixel (IMG_WIDTH-1, 3).
  - STREAM: each accept with x>=4 loads the output register, with window_valid=1 on the next cycle. The loaded window has bottom-right = the accepted pixel, win_x=x-2, win_y=y-2. Accepts with x<4 produce no window.
  - On accepting the last pixel of the frame, the window is loaded with window_last=1 and the FSM returns to FILL.
- Latency: exactly 1 cycle from the accepting edge to window_valid.
- Window count: (IMG_WIDTH-4)*(IMG_HEIGHT-4) windows per frame.
- Frame isolation: rows from the previous frame are never exposed, because the y<4 gating applies at every frame start. Back-to-back frames need no idle cycles.
- Simultaneous consume and accept: window_valid remains 1 with the new contents if the accepted pixel produces a window; otherwise it drops to 0.
- Arithmetic is unsigned; counters are 12 bits.

Test Plan (IMG_WIDTH=8, IMG_HEIGHT=6, pixel value = 16*y + x):
- Continuous stream, window_ready=1: first window_valid occurs one cycle after the 37th pixel (x=4, y=4). Required fields: row0col0=0x00, centre=0x22, row4col4=0x44, win_x=2, win_y=2.
- Full frame count: exactly 8 windows. The last has row4col4=0x57, win_x=5, win_y=3, window_last=1; all others have window_last=0.
- Backpressure: hold window_ready=0 for 3 cycles while a window is pending. Required: window_out is unchanged, pix_ready=0, and no pixels are lost. Final window count is still 8 with correct values.
- Reset mid-frame: rst for 1 cycle after 20 pixels. Required: window_valid=0 and pix_ready=1 next cycle. Restart the frame; the first window again has centre 0x22.
- Back-to-back frames, second frame values +0x80 (mod 256): the first window of frame 2 has row0col0=0x80 and centre=0xA2, with no frame-1 bytes anywhere in the window.
- Random pix_valid/window_ready gaps (50%): the output sequence is bit-identical to the continuous run.
